// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of the two requesters sharing one ALU.
// The master side is the requester and the slave side is the arbiter.
interface alu_share_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int OP_W   = 4
);
   logic              req0_valid;
   logic              req0_ready;
   logic [OP_W-1:0]   req0_op;
   logic [DATA_W-1:0] req0_a;
   logic [DATA_W-1:0] req0_b;
   logic              rsp0_valid;
   logic              rsp0_ready;
   logic [DATA_W-1:0] rsp0_result;
   logic              rsp0_zero;

   logic              req1_valid;
   logic              req1_ready;
   logic [OP_W-1:0]   req1_op;
   logic [DATA_W-1:0] req1_a;
   logic [DATA_W-1:0] req1_b;
   logic              rsp1_valid;
   logic              rsp1_ready;
   logic [DATA_W-1:0] rsp1_result;
   logic              rsp1_zero;

   modport master (
      output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
      input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero
   );

   modport slave (
      input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
      input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
      output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
      output req1_ready, rsp1_valid, rsp1_result, rsp1_zero
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// each with a one-entry registered response slot.
module alu_share_arbiter #(
   parameter int              DATA_W  = 32,
   parameter int              OP_W    = 4,
   parameter logic [OP_W-1:0] IDLE_OP = OP_W'(4'b1111)
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_arbiter_if.slave bus,
   output logic [OP_W-1:0]   alu_opcode,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   logic [1:0]        req_valid;
   logic [1:0]        rsp_ready;
   logic [1:0]        eligible;
   logic [1:0]        grant;

   logic              last_grant_q, last_grant_d;
   logic [1:0]        rsp_valid_q, rsp_valid_d;
   logic [1:0]        rsp_zero_q, rsp_zero_d;
   logic [DATA_W-1:0] rsp_result_q [2];
   logic [DATA_W-1:0] rsp_result_d [2];

   assign req_valid = {bus.req1_valid, bus.req0_valid};
   assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

   // A port may be granted only if its response slot is free or draining now;
   // a tie goes to the port that did not win the last accept.
   always_comb begin : arbitrate
      eligible = {2{~rst}} & req_valid & (~rsp_valid_q | rsp_ready);
      if (&eligible) grant = last_grant_q ? 2'b01 : 2'b10;
      else           grant = eligible;
   end

   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];

   always_comb begin : alu_drive
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      alu_opcode = IDLE_OP;
      alu_op1    = '0;
      alu_op2    = '0;
      if (grant[0]) begin
         alu_opcode = bus.req0_op;
         alu_op1    = bus.req0_a;
         alu_op2    = bus.req0_b;
      end else if (grant[1]) begin
         alu_opcode = bus.req1_op;
         alu_op1    = bus.req1_a;
         alu_op2    = bus.req1_b;
      end
   end

   // Drain clears the slot; a same-cycle accept overrides the drain.
   always_comb begin : next_state
      last_grant_d = last_grant_q;
      rsp_valid_d  = rsp_valid_q & ~rsp_ready;
      rsp_zero_d   = rsp_zero_q;
      rsp_result_d = rsp_result_q;
      for (int p = 0; p < 2; p++) begin
         if (grant[p]) begin
            rsp_valid_d[p]  = 1'b1;
            rsp_result_d[p] = alu_result;
            rsp_zero_d[p]   = alu_zero;
            last_grant_d    = 1'(p);
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         last_grant_q <= 1'b1;
         rsp_valid_q  <= '0;
         rsp_zero_q   <= '0;
         for (int p = 0; p < 2; p++) rsp_result_q[p] <= '0;
      end else begin
         last_grant_q <= last_grant_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_zero_q   <= rsp_zero_d;
         for (int p = 0; p < 2; p++) rsp_result_q[p] <= rsp_result_d[p];
      end
   end

   assign bus.rsp0_valid  = rsp_valid_q[0];
   assign bus.rsp0_result = rsp_result_q[0];
   assign bus.rsp0_zero   = rsp_zero_q[0];
   assign bus.rsp1_valid  = rsp_valid_q[1];
   assign bus.rsp1_result = rsp_result_q[1];
   assign bus.rsp1_zero   = rsp_zero_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus random
// traffic, compared every cycle against a transaction-level model.
module tb_alu_share_arbiter;

   localparam int DATA_W = 32;
   localparam int OP_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic [OP_W-1:0]   alu_opcode;
   logic [DATA_W-1:0] alu_op1, alu_op2, alu_result;
   logic              alu_zero;

   // Stimulus per port
   logic              vld  [2];
   logic [OP_W-1:0]   op   [2];
   logic [DATA_W-1:0] opa  [2];
   logic [DATA_W-1:0] opb  [2];
   logic              rrdy [2];

   // Model of architectural state
   bit                m_v    [2];
   logic [DATA_W-1:0] m_r    [2];
   bit                m_z    [2];
   int                m_last;
   int                acc;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

   assign bus.req0_valid = vld[0];
   assign bus.req0_op    = op[0];
   assign bus.req0_a     = opa[0];
   assign bus.req0_b     = opb[0];
   assign bus.rsp0_ready = rrdy[0];
   assign bus.req1_valid = vld[1];
   assign bus.req1_op    = op[1];
   assign bus.req1_a     = opa[1];
   assign bus.req1_b     = opb[1];
   assign bus.rsp1_ready = rrdy[1];

   alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .IDLE_OP(4'b1111)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .alu_opcode (alu_opcode),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_result (alu_result),
      .alu_zero   (alu_zero)
   );

   function automatic logic [31:0] alu_ref(logic [3:0] o, logic [31:0] a, logic [31:0] b);
      logic signed [31:0] sa;
      sa = a;
      case (o)
         4'd0:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd1:    return a + b;
         4'd2:    return a - b;
         4'd3:    return a & b;
         4'd4:    return a | b;
         4'd5:    return a << b[4:0];
         4'd6:    return a >> b[4:0];
         4'd7:    return a ^ b;
         4'd10:   return sa >>> b[4:0];
         4'd11:   return (a < b) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Behavioural ALU attached to the arbiter
   assign alu_result = alu_ref(alu_opcode, alu_op1, alu_op2);
   assign alu_zero   = (alu_result == '0);

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_req(input int p, input bit v, input logic [3:0] o,
                          input logic [31:0] a, input logic [31:0] b);
      vld[p] = v;
      op[p]  = o;
      opa[p] = a;
      opb[p] = b;
   endtask

   // One clock cycle: check outputs against the model mid-cycle, then advance it.
   task automatic tick();
      bit e0, e1;
      int g;
      logic [3:0]  x_op;
      logic [31:0] x_a, x_b;
      @(negedge clk);
      e0 = !rst && vld[0] && (!m_v[0] || rrdy[0]);
      e1 = !rst && vld[1] && (!m_v[1] || rrdy[1]);
      if (e0 && e1)  g = (m_last == 0) ? 1 : 0;
      else if (e0)   g = 0;
      else if (e1)   g = 1;
      else           g = -1;
      x_op = (g < 0) ? 4'hF  : op[g];
      x_a  = (g < 0) ? 32'd0 : opa[g];
      x_b  = (g < 0) ? 32'd0 : opb[g];
      check("req0_ready", 64'(bus.req0_ready), 64'(g == 0));
      check("req1_ready", 64'(bus.req1_ready), 64'(g == 1));
      check("alu_opcode", 64'(alu_opcode), 64'(x_op));
      check("alu_op1",    64'(alu_op1),    64'(x_a));
      check("alu_op2",    64'(alu_op2),    64'(x_b));
      check("rsp0_valid", 64'(bus.rsp0_valid),  64'(m_v[0]));
      check("rsp0_result",64'(bus.rsp0_result), 64'(m_r[0]));
      check("rsp0_zero",  64'(bus.rsp0_zero),   64'(m_z[0]));
      check("rsp1_valid", 64'(bus.rsp1_valid),  64'(m_v[1]));
      check("rsp1_result",64'(bus.rsp1_result), 64'(m_r[1]));
      check("rsp1_zero",  64'(bus.rsp1_zero),   64'(m_z[1]));
      @(posedge clk);
      if (rst) begin
         for (int p = 0; p < 2; p++) begin
            m_v[p] = 0; m_r[p] = '0; m_z[p] = 0;
         end
         m_last = 1;
      end else begin
         for (int p = 0; p < 2; p++) if (m_v[p] && rrdy[p]) m_v[p] = 0;
         if (g >= 0) begin
            m_v[g]  = 1;
            m_r[g]  = alu_ref(op[g], opa[g], opb[g]);
            m_z[g]  = (m_r[g] == '0);
            m_last  = g;
         end
      end
      acc = g;
      #1;
   endtask

   initial begin
      int idx0, idx1;
      logic [3:0] ops [10];
      ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11};
      for (int p = 0; p < 2; p++) begin
         set_req(p, 1'b1, 4'd1, 32'd1, 32'd2);
         rrdy[p] = 1'b1;
         m_v[p] = 0; m_r[p] = '0; m_z[p] = 0;
      end
      m_last = 1;
      acc    = -1;

      // Reset with requests pending: nothing is granted, ALU idles
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Single ADD on port 0
      set_req(0, 1'b1, 4'd1, 32'd5, 32'd7);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      check("add_valid",  64'(bus.rsp0_valid),  64'd1);
      check("add_result", 64'(bus.rsp0_result), 64'd12);
      check("add_zero",   64'(bus.rsp0_zero),   64'd0);
      tick();

      // Fresh reset, then a tie on the first cycle
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_req(0, 1'b1, 4'd2, 32'd3, 32'd3);
      set_req(1, 1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1);
      tick();
      check("tie_first_port0", 64'(acc), 64'd0);
      check("sub_zero_result", 64'(bus.rsp0_result), 64'd0);
      check("sub_zero_flag",   64'(bus.rsp0_zero),   64'd1);
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();
      check("tie_second_port1", 64'(acc), 64'd1);
      check("slt_result",       64'(bus.rsp1_result), 64'd1);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);

      // Both stream with immediate drain: grants alternate
      idx0 = 0; idx1 = 0;
      set_req(0, 1'b1, 4'd10, 32'h8000_0000, 32'd4);
      set_req(1, 1'b1, 4'd11, 32'd1, 32'hFFFF_FFFF);
      for (int c = 0; c < 8; c++) begin
         tick();
         check("alternate", 64'(acc), 64'(c % 2));
         if (c == 1) begin
            check("sra_result",  64'(bus.rsp0_result), 64'hF800_0000);
            check("sltu_result", 64'(bus.rsp1_result), 64'd1);
         end
         if (acc == 0) begin
            idx0++;
            set_req(0, 1'b1, ops[idx0 % 10], $urandom, $urandom);
         end else if (acc == 1) begin
            idx1++;
            set_req(1, 1'b1, ops[idx1 % 10], $urandom, $urandom);
         end
      end
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();

      // Back-pressure on port 1 while port 0 takes every cycle
      rrdy[1] = 1'b0;
      set_req(1, 1'b1, 4'd7, 32'hFF, 32'h0F);
      tick();
      set_req(1, 1'b1, 4'd1, 32'd1, 32'd1);
      for (int c = 0; c < 5; c++) begin
         set_req(0, 1'b1, ops[$urandom_range(0, 9)], $urandom, $urandom);
         tick();
         check("bp_port0_wins", 64'(acc), 64'd0);
         check("bp_rsp1_hold",  64'(bus.rsp1_result), 64'h0000_00F0);
      end
      rrdy[1] = 1'b1;
      tick();
      check("drain_accept_port1", 64'(acc), 64'd1);
      check("drain_accept_valid", 64'(bus.rsp1_valid), 64'd1);
      check("drain_accept_data",  64'(bus.rsp1_result), 64'd2);
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      set_req(1, 1'b0, 4'd0, 32'd0, 32'd0);

      // Unlisted opcode, then an idle cycle
      set_req(0, 1'b1, 4'b1000, 32'd9, 32'd9);
      tick();
      check("undef_result", 64'(bus.rsp0_result), 64'd0);
      check("undef_zero",   64'(bus.rsp0_zero),   64'd1);
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      tick();

      // Reset while a response is pending
      rrdy[0] = 1'b0;
      set_req(0, 1'b1, 4'd1, 32'd40, 32'd2);
      tick();
      set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_rsp0_valid",  64'(bus.rsp0_valid),  64'd0);
      check("rst_rsp0_result", 64'(bus.rsp0_result), 64'd0);
      rrdy[0] = 1'b1;
      set_req(0, 1'b1, 4'd3, 32'hF0F0, 32'hFF00);
      set_req(1, 1'b1, 4'd4, 32'h1, 32'h2);
      tick();
      check("post_rst_tie", 64'(acc), 64'd0);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         for (int p = 0; p < 2; p++) begin
            set_req(p, 1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : ops[$urandom_range(0, 9)],
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    $urandom);
            rrdy[p] = 1'($urandom_range(0, 2) != 0);
         end
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Round-robin arbiter that shares the single-cycle combinational ALU between two requesters, e.g. the integer execute stage (port 0) and the address/branch helper (port 1). Each port has a valid/ready request channel and a one-entry registered response channel. The arbiter drives the ALU operands and opcode from the granted request and captures the ALU result and zero flag into that port's response register. Throughput is one operation per cycle in total.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width
- IDLE_OP, 4'b1111, opcode driven to the ALU when nothing is granted (decodes to result 0)
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- reqN_valid  in  1  request valid, N∈{0,1}
- reqN_ready  out  1  request accepted this cycle when valid&ready
- reqN_op  in  OP_W  ALU opcode: SLT=0, ADD=1, SUB=2, AND=3, OR=4, SLL=5, SRL=6, XOR=7, SRA=10, SLTU=11
- reqN_a, reqN_b  in  DATA_W  operand 1, operand 2
- rspN_valid  out  1  response held valid
- rspN_ready  in  1  response consumed when valid&ready
- rspN_result  out  DATA_W  captured ALU result
- rspN_zero  out  1  captured ALU zero flag
- alu_opcode  out  OP_W  to ALU opcode
- alu_op1, alu_op2  out  DATA_W  to ALU operands
- alu_result  in  DATA_W  from ALU, combinational
- alu_zero  in  1  from ALU, combinational

## Operation
- eligibleN = reqN_valid & (~rspN_valid | rspN_ready); the response slot is free or draining this cycle.
- Grant: if exactly one port is eligible, that port wins. If both are eligible, the port ≠ last_grant wins. If none is eligible, there is no grant.
- reqN_ready = (grant == N). It is combinational from valid, rsp state and last_grant, and is never asserted for an ineligible port.
- While a port is granted, alu_opcode/alu_op1/alu_op2 = reqN_op/reqN_a/reqN_b. With no grant they are IDLE_OP/0/0.
- At the edge of an accepted request:
  - rspN_result ← alu_result
  - rspN_zero ← alu_zero
  - rspN_valid ← 1
  - last_grant ← N
- At the edge where rspN_valid & rspN_ready and there is no new accept for port N: rspN_valid ← 0. rspN_result and rspN_zero hold their last values.
- Drain and accept on the same port in the same cycle: the new result overwrites the slot and rspN_valid stays 1.
- Opcodes outside the listed set pass through unchanged. The response carries the ALU result 0, with zero=1.
- No width extension: results are exactly DATA_W, as produced by the ALU.
- last_grant updates only on an accept. An idle cycle does not change priority.
- Internal state: last_grant (1 bit), plus rsp_valid, result and zero for each port. No other FSM.

## Timing
- Reset values: rspN_valid=0, rspN_result=0, rspN_zero=0, last_grant=1 (port 0 wins the first tie).
- During reset: reqN_ready=0 and the ALU drive is IDLE_OP/0/0.
- Latency: request accepted at edge k → rspN_valid=1 from edge k through the cycle after it, with data stable until consumed.
- Response holding: rspN_result and rspN_zero stay constant while rspN_valid=1 and rspN_ready=0.
- Fairness: when both ports request continuously and drain immediately, grants alternate 0,1,0,1. A port waits at most 1 cycle.
- Back-pressure: with rspN_ready=0 and rspN_valid=1, port N is ineligible and the other port may take every cycle.
- Reset asserted mid-operation: pending responses are discarded at that edge. No request is accepted in a cycle where rst=1.

## Test plan
- Reset, then req0: ADD 5+7 → req0_ready=1 in the same cycle; next cycle rsp0_valid=1, rsp0_result=12, rsp0_zero=0.
- Both valid on the first cycle after reset: req0 SUB 3-3, req1 SLT -1<1 → port 0 is granted first with rsp0 result 0, zero=1. Port 1 is granted next cycle with rsp1 result 1.
- Both stream continuously with rsp_ready=1 → grants alternate 0,1,0,1 for 8 cycles, and each result matches the model (SRA 0x80000000>>>4 = 0xF8000000, SLTU 1<0xFFFFFFFF = 1).
- rsp1_ready=0 with rsp1 holding XOR 0xFF^0x0F=0xF0 → req1_ready=0 and rsp1_result stays 0xF0 for 5 cycles while port 0 is granted every cycle. Raising rsp1_ready then drains it and accepts the next req1 in the same cycle.
- Opcode 4'b1000 with operands 9 and 9 → result 0, zero=1. In an idle cycle the bench observes alu_opcode=4'b1111 and operands 0.
- rst asserted while rsp0_valid=1 → next cycle rsp0_valid=0 and rsp0_result=0. After release, a tie goes to port 0.
